// File: rtl/csa_accumulator_29bit_pkg.sv
// Shared definitions for the 29-bit streaming accumulator: FSM state
// encoding and the block geometry of the carry-select adder.
package csa_accumulator_29bit_pkg;

    // Packet FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // accumulator empty, waiting for the first term
        ST_ACC  = 2'd1,   // partial packet in progress
        ST_DONE = 2'd2    // packet result held for the sink
    } state_t;

    // Bits per carry-select block inside csa_29bit.
    localparam int CSA_BLOCK = 4;

    // Number of carry-select blocks needed to cover a w-bit operand.
    // The last block is narrower when w is not a multiple of CSA_BLOCK.
    function automatic int csa_num_blocks(input int w);
        return (w + CSA_BLOCK - 1) / CSA_BLOCK;
    endfunction

endpackage

// File: rtl/csa_accumulator_29bit_csa.sv
// csa_29bit: combinational two-operand carry-select adder.
// Each block precomputes its sum for carry-in 0 and 1; the block carry
// chain then only walks through one mux per block.
module csa_29bit
    import csa_accumulator_29bit_pkg::*;
#(
    parameter int WIDTH = 29
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NB = csa_num_blocks(WIDTH);

    // carry[gi] is the carry into block gi; carry[NB] is the final carry out.
    logic [NB:0] carry;

    assign carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi = gi + 1) begin : g_block
            localparam int LO = gi * CSA_BLOCK;
            localparam int HI = (((LO + CSA_BLOCK) < WIDTH) ? (LO + CSA_BLOCK) : WIDTH) - 1;
            localparam int BW = HI - LO + 1;

            logic [BW:0] sum_c0;
            logic [BW:0] sum_c1;

            // Both candidate sums, one extra bit for the block carry.
            // sum_c1 cannot overflow BW+1 bits: max is 2*(2^BW-1)+1.
            assign sum_c0 = {1'b0, a[HI:LO]} + {1'b0, b[HI:LO]};
            assign sum_c1 = sum_c0 + {{BW{1'b0}}, 1'b1};

            // Select the candidate matching the real incoming carry.
            assign sum[HI:LO]    = carry[gi] ? sum_c1[BW-1:0] : sum_c0[BW-1:0];
            assign carry[gi + 1] = carry[gi] ? sum_c1[BW]     : sum_c0[BW];
        end
    endgenerate

    assign cout = carry[NB];

endmodule

// File: rtl/csa_accumulator_29bit.sv
// csa_accumulator_29bit: streaming packet accumulator around csa_29bit.
// Accepts up to NUM_TERMS terms per packet (or fewer when i_last is seen),
// sums them modulo 2^WIDTH, tracks a sticky carry-out flag and a term count,
// and holds the packet result until the sink takes it.
module csa_accumulator_29bit
    import csa_accumulator_29bit_pkg::*;
#(
    parameter int WIDTH     = 29,
    parameter int NUM_TERMS = 8,
    parameter int CNT_W     = $clog2(NUM_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_reg, state_next;
    logic             ready_reg, ready_next;
    logic [WIDTH-1:0] acc_reg,   acc_next;
    logic             ovf_reg,   ovf_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             accept;
    logic             close_pkt;
    logic             release_pkt;
    logic [CNT_W-1:0] cnt_inc;

    // The adder always sees acc + i_data; its result is only used on accept.
    csa_29bit #(
        .WIDTH (WIDTH)
    ) u_csa (
        .a    (acc_reg),
        .b    (i_data),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept      = i_valid & ready_reg;
    assign cnt_inc     = cnt_reg + CNT_ONE;
    assign close_pkt   = (cnt_inc == LAST_CNT) | i_last;
    assign release_pkt = (state_reg == ST_DONE) & i_ready;

    // State register; o_ready is held low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= ready_next;
        end
    end

    // Next-state logic: a closing term moves to DONE, the sink handshake back to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_ACC: begin
                if (accept) begin
                    state_next = close_pkt ? ST_DONE : ST_ACC;
                end
            end
            ST_DONE: begin
                if (i_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: accept terms in every state except while a result is held.
    always_comb begin
        ready_next = (state_next != ST_DONE);
    end

    // Datapath next values: fold in an accepted term, or clear once the result is taken.
    always_comb begin
        acc_next = acc_reg;
        ovf_next = ovf_reg;
        cnt_next = cnt_reg;
        if (accept) begin
            acc_next = add_sum;
            ovf_next = ovf_reg | add_cout;
            cnt_next = cnt_inc;
        end else if (release_pkt) begin
            acc_next = '0;
            ovf_next = 1'b0;
            cnt_next = '0;
        end
    end

    // Datapath registers; these directly drive the result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            ovf_reg <= 1'b0;
            cnt_reg <= '0;
        end else begin
            acc_reg <= acc_next;
            ovf_reg <= ovf_next;
            cnt_reg <= cnt_next;
        end
    end

    assign o_ready  = ready_reg;
    assign o_valid  = (state_reg == ST_DONE);
    assign o_result = acc_reg;
    assign o_ovf    = ovf_reg;
    assign o_count  = cnt_reg;

endmodule
